// File: rtl/vga_layer_pkg.sv
// vga_layer_pkg: shared definitions for the VGA layer scheduler.
// Register map, FSM state encoding, visible-vector bit positions (also used
// by the RGB mux) and the configuration register bundle.
package vga_layer_pkg;

    // Configuration register addresses
    localparam logic [2:0] CFG_SP1_X = 3'd0;
    localparam logic [2:0] CFG_SP1_Y = 3'd1;
    localparam logic [2:0] CFG_SP2_X = 3'd2;
    localparam logic [2:0] CFG_SP2_Y = 3'd3;
    localparam logic [2:0] CFG_EN    = 3'd4;

    // Bit positions inside the visible vector and the enable register
    localparam int VIS_SP1   = 0;
    localparam int VIS_SP2   = 1;
    localparam int VIS_LINES = 2;

    // Commit FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRTY  = 2'd1,
        COMMIT = 2'd2
    } layer_state_e;

    // One full set of layer configuration (used for both shadow and active copies)
    typedef struct packed {
        logic [9:0] sp1_x;
        logic [9:0] sp1_y;
        logic [9:0] sp2_x;
        logic [9:0] sp2_y;
        logic [2:0] en;
    } layer_cfg_t;

    // Apply one register write to a configuration set; unmapped addresses leave it unchanged.
    function automatic layer_cfg_t cfg_apply(input layer_cfg_t cur,
                                             input logic [2:0] addr,
                                             input logic [9:0] data);
        layer_cfg_t nxt;
        nxt = cur;
        case (addr)
            CFG_SP1_X: nxt.sp1_x = data;
            CFG_SP1_Y: nxt.sp1_y = data;
            CFG_SP2_X: nxt.sp2_x = data;
            CFG_SP2_Y: nxt.sp2_y = data;
            CFG_EN:    nxt.en    = data[2:0];
            default:   nxt       = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/vga_sprite_hit.sv
// vga_sprite_hit: combinational rectangle test for one sprite.
// The right/bottom edges are computed in 11 bits so a sprite near the screen
// edge is clipped instead of wrapping back to column/row 0.
module vga_sprite_hit #(
    parameter int SPR_W = 32,
    parameter int SPR_H = 32
) (
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic [9:0] pos_x,
    input  logic [9:0] pos_y,
    input  logic       en,
    output logic       hit
);

    localparam logic [10:0] W_EXT = 11'(SPR_W);
    localparam logic [10:0] H_EXT = 11'(SPR_H);

    logic [10:0] x_end;
    logic [10:0] y_end;

    // Pixel lies inside [pos, pos+size) on both axes and the sprite is enabled
    always_comb begin
        x_end = {1'b0, pos_x} + W_EXT;
        y_end = {1'b0, pos_y} + H_EXT;
        hit   = en
              && (x >= pos_x) && ({1'b0, x} < x_end)
              && (y >= pos_y) && ({1'b0, y} < y_end);
    end

endmodule

// File: rtl/vga_layer_ctrl.sv
// vga_layer_ctrl: per-pixel layer scheduler for the VGA output mux.
// Holds sprite positions and layer enables in a shadow copy that is written
// through a valid/ready port and copied to the active copy only at frame start,
// so the picture never tears mid-frame. Produces the registered 3-bit visible
// vector {lines, sp2, sp1} one cycle after x/y/video_on.
// Optional feature: define VGA_LAYER_BLINK_EN to blink sprite 2 with a
// half-period of 2^BLINK_LOG2 frames.
module vga_layer_ctrl
    import vga_layer_pkg::*;
#(
    parameter int SPR_W           = 32,
    parameter int SPR_H           = 32,
    parameter int LINE_PITCH_LOG2 = 5,
    parameter int BLINK_LOG2      = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       video_on,
    input  logic       frame_start,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [2:0] cfg_addr,
    input  logic [9:0] cfg_data,
    output logic [2:0] visible,
    output logic       commit_done
);

    layer_state_e state_q, state_d;
    logic         cfg_ready_q, cfg_ready_d;
    logic         commit_done_q, commit_done_d;

    layer_cfg_t   shadow_q, shadow_d;
    layer_cfg_t   active_q, active_d;

    logic [7:0]   frame_cnt_q, frame_cnt_d;
    logic [2:0]   visible_q, visible_d;

    logic         wr_acc;
    logic         sp1_hit;
    logic         sp2_hit;
    logic         lines_hit;
    logic         blink_on;

    // A write is taken whenever the port is ready; ready only drops while committing
    always_comb begin
        wr_acc   = cfg_valid && cfg_ready_q;
        shadow_d = shadow_q;
        if (wr_acc) begin
            shadow_d = cfg_apply(shadow_q, cfg_addr, cfg_data);
        end
    end

    // Commit FSM next state; the registered outputs are derived from the next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                // A write coinciding with frame_start only marks the shadow dirty;
                // it is committed at the following frame start.
                if (wr_acc) begin
                    state_d = DIRTY;
                end
            end
            DIRTY: begin
                // A same-cycle write lands in shadow now and is part of the copy.
                if (frame_start) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        cfg_ready_d   = (state_d != COMMIT);
        commit_done_d = (state_d == COMMIT);
    end

    // Commit FSM state and its registered handshake/status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cfg_ready_q   <= 1'b1;
            commit_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cfg_ready_q   <= cfg_ready_d;
            commit_done_q <= commit_done_d;
        end
    end

    // Active copy follows shadow only during the single COMMIT cycle
    always_comb begin
        active_d = active_q;
        if (state_q == COMMIT) begin
            active_d = shadow_q;
        end
    end

    // Frame counter advances on every frame start and wraps naturally at 8 bits
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_start) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end

    // Configuration copies and frame counter; a reset discards pending shadow writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q    <= '0;
            active_q    <= '0;
            frame_cnt_q <= 8'd0;
        end else begin
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    vga_sprite_hit #(
        .SPR_W (SPR_W),
        .SPR_H (SPR_H)
    ) u_sp1_hit (
        .x     (x),
        .y     (y),
        .pos_x (active_q.sp1_x),
        .pos_y (active_q.sp1_y),
        .en    (active_q.en[VIS_SP1]),
        .hit   (sp1_hit)
    );

    vga_sprite_hit #(
        .SPR_W (SPR_W),
        .SPR_H (SPR_H)
    ) u_sp2_hit (
        .x     (x),
        .y     (y),
        .pos_x (active_q.sp2_x),
        .pos_y (active_q.sp2_y),
        .en    (active_q.en[VIS_SP2]),
        .hit   (sp2_hit)
    );

`ifdef VGA_LAYER_BLINK_EN
    // Sprite 2 is shown while the selected frame-counter bit is low
    assign blink_on = ~frame_cnt_q[BLINK_LOG2];
`else
    // Without blinking the frame counter has no consumer
    logic unused_frame_cnt;
    assign blink_on         = 1'b1;
    assign unused_frame_cnt = ^{frame_cnt_q, frame_cnt_q[BLINK_LOG2]};
`endif

    // Grid lines on every 2^LINE_PITCH_LOG2-th column and row
    always_comb begin
        lines_hit = active_q.en[VIS_LINES]
                 && ((x[LINE_PITCH_LOG2-1:0] == '0) || (y[LINE_PITCH_LOG2-1:0] == '0));
    end

    // Assemble the visible vector; blanking forces all layers off
    always_comb begin
        visible_d = 3'b000;
        if (video_on) begin
            visible_d[VIS_SP1]   = sp1_hit;
            visible_d[VIS_SP2]   = sp2_hit && blink_on;
            visible_d[VIS_LINES] = lines_hit;
        end
    end

    // Visible vector register: one pixel clock of latency from x/y/video_on
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            visible_q <= 3'b000;
        end else begin
            visible_q <= visible_d;
        end
    end

    assign cfg_ready   = cfg_ready_q;
    assign commit_done = commit_done_q;
    assign visible     = visible_q;

endmodule

// File: tb/tb_vga_layer_ctrl.sv
// tb_vga_layer_ctrl: directed bench for vga_layer_ctrl (BLINK_LOG2 = 1 so the
// blink section is short when VGA_LAYER_BLINK_EN is defined).
module tb_vga_layer_ctrl;

    logic       clk;
    logic       rst_n;
    logic [9:0] x;
    logic [9:0] y;
    logic       video_on;
    logic       frame_start;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [2:0] cfg_addr;
    logic [9:0] cfg_data;
    logic [2:0] visible;
    logic       commit_done;

    int tests_run;
    int tests_failed;
    logic blink_exp [6];

    vga_layer_ctrl #(
        .SPR_W           (32),
        .SPR_H           (32),
        .LINE_PITCH_LOG2 (5),
        .BLINK_LOG2      (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .x           (x),
        .y           (y),
        .video_on    (video_on),
        .frame_start (frame_start),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .visible     (visible),
        .commit_done (commit_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_v(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic wr(input int a, input int d);
        cfg_valid = 1'b1;
        cfg_addr  = 3'(a);
        cfg_data  = 10'(d);
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic pix(input int px, input int py, input logic v);
        x        = 10'(px);
        y        = 10'(py);
        video_on = v;
        tick();
    endtask

    task automatic commit(input string tag);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk_b({tag, "_done_hi"}, commit_done, 1'b1);
        chk_b({tag, "_ready_lo"}, cfg_ready, 1'b0);
        tick();
        chk_b({tag, "_done_lo"}, commit_done, 1'b0);
        chk_b({tag, "_ready_hi"}, cfg_ready, 1'b1);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        x            = '0;
        y            = '0;
        video_on     = 1'b0;
        frame_start  = 1'b0;
        cfg_valid    = 1'b0;
        cfg_addr     = '0;
        cfg_data     = '0;

        // Reset state
        tick(); tick();
        chk_v("rst_visible", visible, 3'b000);
        chk_b("rst_ready", cfg_ready, 1'b1);
        chk_b("rst_done", commit_done, 1'b0);
        rst_n = 1'b1;
        tick();

        // Writes land in shadow only until frame start
        wr(0, 100);
        wr(1, 50);
        wr(4, 3'b001);
        pix(110, 60, 1'b1);
        chk_v("precommit_vis", visible, 3'b000);
        chk_b("precommit_done", commit_done, 1'b0);
        commit("c1");
        pix(110, 60, 1'b1);
        chk_v("sp1_hit", visible, 3'b001);

        // Sprite 1 boundaries at (100,50), 32x32
        pix(131, 60, 1'b1); chk_v("sp1_x131", visible, 3'b001);
        pix(132, 60, 1'b1); chk_v("sp1_x132", visible, 3'b000);
        pix(99, 60, 1'b1);  chk_v("sp1_x99", visible, 3'b000);
        pix(110, 81, 1'b1); chk_v("sp1_y81", visible, 3'b001);
        pix(110, 82, 1'b1); chk_v("sp1_y82", visible, 3'b000);

        // Overlap, grid lines and blanking
        wr(2, 100);
        wr(3, 50);
        wr(4, 3'b111);
        commit("c2");
        pix(128, 60, 1'b1);  chk_v("overlap_all", visible, 3'b111);
        pix(128, 200, 1'b1); chk_v("lines_only", visible, 3'b100);
        pix(128, 200, 1'b0); chk_v("blanked", visible, 3'b000);
        pix(130, 61, 1'b1);  chk_v("sprites_no_line", visible, 3'b011);

        // Clipping at the right edge
        wr(0, 1020);
        wr(4, 3'b001);
        commit("c3");
        pix(1023, 60, 1'b1); chk_v("clip_x1023", visible, 3'b001);
        pix(0, 60, 1'b1);    chk_v("clip_x0", visible, 3'b000);

        // Enable sprite 2 only at (100,50)
        wr(4, 3'b010);
        commit("c4");

        // Write together with frame_start in IDLE: no commit this frame
        cfg_valid   = 1'b1;
        cfg_addr    = 3'd2;
        cfg_data    = 10'd200;
        frame_start = 1'b1;
        tick();
        cfg_valid   = 1'b0;
        frame_start = 1'b0;
        chk_b("idle_sim_no_done", commit_done, 1'b0);
        chk_b("idle_sim_ready", cfg_ready, 1'b1);
        pix(110, 60, 1'b1);
        chk_v("idle_sim_old_pos", visible, 3'b010);
        chk_b("idle_sim_still_no_done", commit_done, 1'b0);
        commit("c5");
        pix(110, 60, 1'b1); chk_v("idle_sim_moved_away", visible, 3'b000);
        pix(210, 60, 1'b1); chk_v("idle_sim_new_pos", visible, 3'b010);

        // Write together with frame_start in DIRTY: included in this commit
        wr(3, 100);
        cfg_valid   = 1'b1;
        cfg_addr    = 3'd2;
        cfg_data    = 10'd300;
        frame_start = 1'b1;
        tick();
        cfg_valid   = 1'b0;
        frame_start = 1'b0;
        chk_b("dirty_sim_done", commit_done, 1'b1);
        tick();
        chk_b("dirty_sim_done_lo", commit_done, 1'b0);
        pix(210, 60, 1'b1);  chk_v("dirty_sim_old_gone", visible, 3'b000);
        pix(310, 110, 1'b1); chk_v("dirty_sim_new_pos", visible, 3'b010);

        // Reset in the middle of COMMIT
        wr(0, 10);
        wr(4, 3'b111);
        chk_v("prereset_vis", visible, 3'b010);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk_b("prereset_in_commit", commit_done, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_v("midcommit_rst_vis", visible, 3'b000);
        chk_b("midcommit_rst_ready", cfg_ready, 1'b1);
        chk_b("midcommit_rst_done", commit_done, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        pix(0, 0, 1'b1);   chk_v("postrst_line_pix", visible, 3'b000);
        pix(310, 110, 1'b1); chk_v("postrst_sp2_pix", visible, 3'b000);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk_b("postrst_no_commit", commit_done, 1'b0);
        pix(0, 0, 1'b1);   chk_v("postrst_shadow_lost", visible, 3'b000);

        // Sprite 2 across frames (blinks only when the feature is built in)
`ifdef VGA_LAYER_BLINK_EN
        blink_exp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
`else
        blink_exp = '{default: 1'b1};
`endif
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        wr(2, 100);
        wr(3, 50);
        wr(4, 3'b010);
        x        = 10'd110;
        y        = 10'd60;
        video_on = 1'b1;
        commit("c6");
        tick();
        chk_v("frame_vis_1", visible, {1'b0, blink_exp[0], 1'b0});
        for (int i = 1; i < 6; i++) begin
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            tick();
            chk_v($sformatf("frame_vis_%0d", i + 1), visible, {1'b0, blink_exp[i], 1'b0});
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
